// File: rtl/bus_arbiter.sv
// Two-master arbiter for the shared serial system bus.
// Grants one master at a time. A grant is held until bus_done, until the owner withdraws its
// request, or until the activity watchdog expires. Every grant is followed by a one-cycle
// release gap.
// Optional feature macro: ROUND_ROBIN_EN.
//   Defined:   ties go to the master that was not granted last.
//   Undefined: master 1 always wins a tie.
module bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd200
) (
  input  logic clk,
  input  logic reset,
  input  logic m1_req,
  input  logic m2_req,
  input  logic bus_done,
  input  logic slave_ready,
  input  logic slave_valid,
  output logic m1_grant,
  output logic m2_grant,
  output logic mux_sel,
  output logic bus_busy,
  output logic timeout_err
);

  typedef enum logic [1:0] {StIdle, StGrant1, StGrant2, StRelease} state_e;

  state_e     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  // last_q: 0 = master 1, 1 = master 2
  logic       last_q, last_d;
  logic       timeout_d;
  logic       m1_grant_d, m2_grant_d, mux_sel_d;

  logic activity;
  logic wd_expired;
  logic tie_to_m2;
  logic pick_m1, pick_m2;
  logic owner_req;

  assign activity   = slave_ready | slave_valid;
  assign wd_expired = !activity && (wd_q == (TIMEOUT - 8'd1));

  // Arbitration decision used from both IDLE and RELEASE.
  always_comb begin
`ifdef ROUND_ROBIN_EN
    tie_to_m2 = !last_q;
`else
    tie_to_m2 = 1'b0;
`endif
    pick_m1 = m1_req && !(m2_req && tie_to_m2);
    pick_m2 = m2_req && !pick_m1;
  end

  // Next-state, watchdog and next-output logic.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    owner_req = (state_q == StGrant2) ? m2_req : m1_req;

    unique case (state_q)
      StIdle, StRelease: begin
        wd_d = 8'd0;
        if (pick_m1) begin
          state_d = StGrant1;
          last_d  = 1'b0;
        end else if (pick_m2) begin
          state_d = StGrant2;
          last_d  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant1, StGrant2: begin
        if (bus_done || !owner_req || wd_expired) begin
          state_d   = StRelease;
          // Only a pure watchdog exit is an error; bus_done wins a collision.
          timeout_d = wd_expired && !bus_done && owner_req;
        end else if (activity) begin
          wd_d = 8'd0;
        end else if (wd_q != 8'hff) begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    m1_grant_d = (state_d == StGrant1);
    m2_grant_d = (state_d == StGrant2);
    // Steering holds its last value whenever no one owns the bus.
    if (m2_grant_d) begin
      mux_sel_d = 1'b1;
    end else if (m1_grant_d) begin
      mux_sel_d = 1'b0;
    end else begin
      mux_sel_d = mux_sel;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wd_q        <= 8'd0;
      last_q      <= 1'b1;
      m1_grant    <= 1'b0;
      m2_grant    <= 1'b0;
      mux_sel     <= 1'b0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      last_q      <= last_d;
      m1_grant    <= m1_grant_d;
      m2_grant    <= m2_grant_d;
      mux_sel     <= mux_sel_d;
      bus_busy    <= m1_grant_d | m2_grant_d;
      timeout_err <= timeout_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter (TIMEOUT = 5).
// Uses a table of vectors, hand-written corner sequences and random traffic. The random
// traffic is checked against an ownership-level reference model.
module tb_bus_arbiter;

  localparam int TO = 5;

  logic clk = 1'b0;
  logic reset, m1_req, m2_req, bus_done, slave_ready, slave_valid;
  logic m1_grant, m2_grant, mux_sel, bus_busy, timeout_err;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, quiet cycles since grant/activity, who was last.
  int         owner;
  int         quiet;
  int         last;
  logic [4:0] exp_vec;

  always #5 clk = ~clk;

  bus_arbiter #(.TIMEOUT(8'd5)) dut (
    .clk        (clk),
    .reset      (reset),
    .m1_req     (m1_req),
    .m2_req     (m2_req),
    .bus_done   (bus_done),
    .slave_ready(slave_ready),
    .slave_valid(slave_valid),
    .m1_grant   (m1_grant),
    .m2_grant   (m2_grant),
    .mux_sel    (mux_sel),
    .bus_busy   (bus_busy),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic       rst;
    logic       r1;
    logic       r2;
    logic       done;
    logic       rdy;
    logic       vld;
    logic [4:0] exp;  // {m1_grant, m2_grant, mux_sel, bus_busy, timeout_err}
  } vec_t;

  function automatic logic [4:0] dut_vec();
    return {m1_grant, m2_grant, mux_sel, bus_busy, timeout_err};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  function automatic int choose(input logic r1, input logic r2);
    if (r1 && r2) begin
`ifdef ROUND_ROBIN_EN
      return (last == 1) ? 2 : 1;
`else
      return 1;
`endif
    end
    if (r1) return 1;
    if (r2) return 2;
    return 0;
  endfunction

  task automatic model_step();
    int  pick;
    bit  act, own_req, timed, to;
    to = 1'b0;
    if (reset) begin
      owner   = 0;
      quiet   = 0;
      last    = 2;
      exp_vec = 5'b0;
      return;
    end
    if (owner != 0) begin
      act     = slave_ready || slave_valid;
      own_req = (owner == 1) ? m1_req : m2_req;
      timed   = !act && (quiet == TO - 1);
      if (bus_done || !own_req || timed) begin
        to    = timed && !bus_done && own_req;
        owner = 0;
      end else begin
        quiet = act ? 0 : ((quiet < 255) ? quiet + 1 : 255);
      end
    end else begin
      pick = choose(m1_req, m2_req);
      if (pick != 0) begin
        owner = pick;
        last  = pick;
        quiet = 0;
      end
    end
    exp_vec[4] = (owner == 1);
    exp_vec[3] = (owner == 2);
    exp_vec[2] = (owner == 2) ? 1'b1 : ((owner == 1) ? 1'b0 : exp_vec[2]);
    exp_vec[1] = (owner != 0);
    exp_vec[0] = to;
  endtask

  // One clock: DUT and model both sample the inputs at the edge; compare 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("model", dut_vec(), exp_vec);
  endtask

  task automatic idle_inputs();
    reset = 0; m1_req = 0; m2_req = 0; bus_done = 0; slave_ready = 0; slave_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cycle();
    reset = 0;
  endtask

  vec_t vecs[10];
  int   got_owner, want_owner, k;
  bit   lost;

  initial begin
    exp_vec = 5'b0;
    owner = 0; quiet = 0; last = 2;
    idle_inputs();

    // rst r1 r2 done rdy vld exp
    vecs[0] = '{1, 0, 0, 0, 0, 0, 5'b00000};
    vecs[1] = '{0, 1, 0, 0, 0, 0, 5'b10010};
    vecs[2] = '{0, 1, 0, 0, 1, 0, 5'b10010};
    vecs[3] = '{0, 1, 0, 1, 0, 0, 5'b00000};
    vecs[4] = '{0, 0, 0, 1, 0, 0, 5'b00000};
    vecs[5] = '{0, 0, 1, 0, 0, 0, 5'b01110};
    vecs[6] = '{0, 0, 1, 1, 0, 0, 5'b00100};
    vecs[7] = '{0, 1, 0, 0, 0, 0, 5'b10010};
    vecs[8] = '{0, 0, 0, 0, 0, 0, 5'b00000};
    vecs[9] = '{0, 0, 0, 0, 0, 0, 5'b00000};
    for (int i = 0; i < 10; i++) begin
      reset = vecs[i].rst; m1_req = vecs[i].r1; m2_req = vecs[i].r2;
      bus_done = vecs[i].done; slave_ready = vecs[i].rdy; slave_valid = vecs[i].vld;
      cycle();
      check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
    end

    // Tie under continuous contention.
    do_reset();
    m1_req = 1; m2_req = 1;
    for (int t = 0; t < 4; t++) begin
      cycle();
      got_owner = m1_grant ? 1 : (m2_grant ? 2 : 0);
`ifdef ROUND_ROBIN_EN
      want_owner = (t % 2 == 0) ? 1 : 2;
`else
      want_owner = 1;
`endif
      check($sformatf("tie_order%0d", t), 5'(got_owner), 5'(want_owner));
      bus_done = 1;
      cycle();
      bus_done = 0;
      check("tie_gap", {m1_grant, m2_grant, bus_busy}, 3'b000);
    end

    // Watchdog expiry with no activity.
    do_reset();
    m2_req = 1;
    cycle();
    check("wd_grant", m2_grant, 1'b1);
    k = 0;
    do begin
      cycle();
      k++;
    end while (m2_grant && k < 20);
    check("wd_cycles", 5'(k), 5'(TO));
    check("wd_err", {timeout_err, m2_grant}, 2'b10);
    cycle();
    check("wd_err_pulse", timeout_err, 1'b0);

    // Periodic activity keeps the grant alive.
    do_reset();
    m2_req = 1;
    cycle();
    lost = 0;
    for (int i = 0; i < 20; i++) begin
      slave_valid = (i % 3 == 2);
      cycle();
      if (!m2_grant || timeout_err) lost = 1;
    end
    slave_valid = 0;
    check("wd_activity", lost, 1'b0);

    // bus_done collides with the watchdog limit.
    do_reset();
    m1_req = 1;
    cycle();
    repeat (TO - 1) cycle();
    bus_done = 1;
    cycle();
    bus_done = 0;
    check("collide", {m1_grant, timeout_err}, 2'b00);

    // Owner withdraws; waiting master follows after one gap cycle.
    do_reset();
    m1_req = 1; m2_req = 1;
    cycle();
    m1_req = 0;
    cycle();
    check("withdraw_gap", {m1_grant, m2_grant}, 2'b00);
    cycle();
    check("withdraw_m2", {m1_grant, m2_grant, mux_sel}, 3'b011);

    // Reset while master 2 owns the bus.
    reset = 1; m1_req = 1;
    cycle();
    check("rst_mid", dut_vec(), 5'b00000);
    reset = 0;
    cycle();
    check("rst_then_m1", {m1_grant, m2_grant}, 2'b10);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) m1_req = ~m1_req;
      if ($urandom_range(0, 7) == 0) m2_req = ~m2_req;
      bus_done    = ($urandom_range(0, 7) == 0);
      slave_ready = ($urandom_range(0, 5) == 0);
      slave_valid = ($urandom_range(0, 5) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the shared serial system bus. Grants bus ownership to one master at a time and steers the shared bus lines to it through `mux_sel`. Holds each grant until the transaction completes, the owner withdraws its request, or a watchdog expires. Sits between the two master ports and the address-decoded slave ports (the slave ports' ready/valid signals are observed here, not driven).

## Interface
Parameters:
- `TIMEOUT`, default 8'd200: granted cycles allowed without bus activity before forced release; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m1_req`  in  1  master 1 request; held high for the whole transaction.
- `m2_req`  in  1  master 2 request; same rules as `m1_req`.
- `bus_done`  in  1  one-cycle pulse from the granted master at the end of its transaction.
- `slave_ready`  in  1  combined slave ready, observed for activity.
- `slave_valid`  in  1  combined slave valid, observed for activity.
- `m1_grant`  out  1  master 1 owns the bus.
- `m2_grant`  out  1  master 2 owns the bus.
- `mux_sel`  out  1  bus line steering: 0 = master 1, 1 = master 2.
- `bus_busy`  out  1  high whenever either grant is high.
- `timeout_err`  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- **States.** Four states: IDLE, GRANT1, GRANT2, RELEASE. An 8-bit watchdog counter `wd`. A `last` register holding the most recently granted master.
- **Reset values.**
  - State = IDLE.
  - `wd` = 0.
  - `last` = master 2, so master 1 wins the first tie.
  - `m1_grant` = `m2_grant` = 0.
  - `mux_sel` = 0.
  - `bus_busy` = 0.
  - `timeout_err` = 0.
- **IDLE.**
  - Only `m1_req` high: go to GRANT1.
  - Only `m2_req` high: go to GRANT2.
  - Both high: go to the master chosen by the arbitration policy (see Configuration).
  - Neither high: stay in IDLE.
- **GRANT1 / GRANT2.**
  - The matching grant is high and `mux_sel` selects that master.
  - On entry: `wd` is cleared and `last` is updated to this master.
  - Exit to RELEASE when any of the following holds:
    - `bus_done` = 1;
    - the owner's request is low;
    - `wd` == `TIMEOUT` - 1 with no activity in the current cycle.
- **Watchdog.**
  - Activity means `slave_ready` or `slave_valid` high in a cycle.
  - On an activity cycle `wd` clears to 0; otherwise it increments.
  - `wd` saturates at 255 and never wraps.
- **timeout_err.** Pulses for exactly one cycle, coincident with the first RELEASE cycle, and only when the watchdog caused the exit.
- **Exit priority.** If `bus_done` and the timeout condition occur in the same cycle, `bus_done` wins and no `timeout_err` is raised.
- **RELEASE.**
  - Lasts exactly one cycle with both grants low; `mux_sel` holds its previous value.
  - Then applies the IDLE decision rules directly: a pending request is granted on the next edge, with no extra IDLE cycle.
- **Grant exclusivity.** `m1_grant` and `m2_grant` are never high simultaneously, including across any switch between masters.
- **Reset mid-operation.** Reset in any state returns all outputs to their reset values on the next edge; an in-flight transaction is abandoned.
- **`bus_done` outside a grant.** Ignored in IDLE and RELEASE.

## Timing
- **Request to grant.** A request sampled high in IDLE at edge k gives a grant high after edge k; latency is 1 cycle.
- **`bus_done` to next grant.** `bus_done` sampled at edge k gives RELEASE after edge k and the next grant after edge k+1. The minimum gap between owners is 1 cycle.
- **Timeout.** Assuming no activity after entry into GRANTx at edge g, the forced release (RELEASE state, `timeout_err` = 1) occurs after edge g+`TIMEOUT`.
- **Output registering.** All outputs are registered, with no combinational path from inputs to outputs. `bus_busy` is the registered OR of the next-state grants.

## Configuration
- **`ROUND_ROBIN_EN` defined.** When both requests are high at a decision point, the master not equal to `last` is granted. This alternates under continuous contention.
- **`ROUND_ROBIN_EN` undefined.** Fixed priority: master 1 always wins a tie. `last` is still maintained but has no effect on arbitration.

## Test plan
- **Single request.** Reset, then `m1_req`=1 → `m1_grant`=1, `mux_sel`=0 one cycle later. `bus_done` pulse → one cycle with both grants 0, then IDLE with `bus_busy`=0.
- **Tie, round-robin.** With `ROUND_ROBIN_EN`, both requests held high across 4 transactions → grant order 1,2,1,2, each separated by one RELEASE cycle.
- **Tie, fixed priority.** Without `ROUND_ROBIN_EN`, same stimulus → grant order 1,1,1,1; `m2_grant` never asserted.
- **Watchdog expiry.** `TIMEOUT`=5, grant master 2, hold `slave_ready`/`slave_valid` low → release 5 cycles after grant with a single-cycle `timeout_err`=1. Repeat with `slave_valid` pulsed every 3 cycles → no timeout.
- **Withdrawal and collision.** Master 1 granted drops `m1_req` mid-transaction → RELEASE next cycle, then `m2_grant` if `m2_req` is high. `bus_done` coinciding with timeout → no `timeout_err`.
- **Reset mid-grant.** Assert `reset` while `m2_grant`=1 → all outputs 0 and state IDLE after the next edge; with `m1_req` high afterwards, master 1 is granted first.
